imem_loader: RTL
================

# imem_loader

Byte-stream loader that writes program words into the instruction memory's write port before instruction fetch runs. It accepts bytes over a valid/ready stream and assembles them little-endian into 32-bit words. Each word is written at consecutive word-aligned byte addresses, matching the fetch PC stepping of +4. Loading ends on the all-zero word, the same exit marker fetch uses, which is itself written; the block then asserts `done`, which releases fetch.

## Interface
- `BASE_ADDR`, default 32'h0000_0000: byte address of the first word written; must be 4-aligned.
- `DEPTH`, default 256: instruction memory capacity in 32-bit words.
- `gated_clk`  input  1  clock.
- `reset`  input  1  reset, asynchronous, active-high.
- `start`  input  1  begin a load; sampled only in IDLE, DONE, ERROR.
- `byte_valid`  input  1  upstream byte available.
- `byte_data`  input  8  upstream byte.
- `byte_ready`  output  1  loader accepts a byte this cycle.
- `wr_en`  output  1  instruction memory write strobe, one cycle per word.
- `wr_addr`  output  32  byte address of the write; always 4-aligned.
- `wr_data`  output  32  word to write.
- `word_count`  output  $clog2(DEPTH)+1  words written in the current load, terminator included.
- `done`  output  1  load finished with a terminator; held until next start.
- `error`  output  1  memory filled without a terminator; held until next start.

## Operation
- States: IDLE, ASSEMBLE, WRITE, DONE, ERROR.
- Byte handshake: a byte transfers on a rising edge where `byte_valid && byte_ready`.
- `byte_ready` = (state == ASSEMBLE); `wr_en` = (state == WRITE). Both decode the state register only; no combinational input-to-output path.
- IDLE, DONE, ERROR on `start`:
  - go to ASSEMBLE;
  - byte_cnt=0, `wr_addr`=BASE_ADDR, `word_count`=0;
  - `done`=0, `error`=0, buffer cleared.
- ASSEMBLE, on each transfer:
  - byte k (k = byte_cnt, 0..3) goes to buffer[8k+7:8k];
  - byte_cnt increments;
  - on the transfer with byte_cnt==3, the completed word loads into `wr_data` and the state goes to WRITE.
- ASSEMBLE: `start` is ignored. `byte_valid` low simply stalls, with no timeout.
- WRITE lasts exactly one cycle with `wr_en`=1, `wr_addr`/`wr_data` stable. At the end of the cycle `word_count` increments, then:
  - `wr_data`==0 -> DONE, `done`=1; `wr_addr` is not advanced;
  - else if `word_count` (pre-increment) == DEPTH-1 -> ERROR, `error`=1; the last memory word holds a non-terminator;
  - else `wr_addr` += 4, byte_cnt=0 -> ASSEMBLE.
- DONE/ERROR: `byte_ready`=0, `wr_en`=0. Bytes offered are not accepted. `wr_addr`, `wr_data`, `word_count` hold their values.
- `wr_addr` arithmetic: 32-bit add, no wrap check needed; the DEPTH limit triggers first.
- Reset, at any time including mid-word or during WRITE:
  - state=IDLE, `byte_ready`=0, `wr_en`=0;
  - `wr_addr`=BASE_ADDR, `wr_data`=0, `word_count`=0, `done`=0, `error`=0;
  - a partially assembled word is discarded and never written.
- `done` and `error` are never both 1.

## Timing
- Reset values: all outputs 0 except `wr_addr`=BASE_ADDR.
- `start` sampled at edge E -> `byte_ready`=1 in the cycle after E.
- 4th byte accepted at edge N:
  - `wr_en`=1 during cycle N..N+1;
  - memory captures the word at edge N+1;
  - `byte_ready` returns to 1 after N+1 for a non-zero word;
  - `done` or `error` is visible after N+1 otherwise.
- Peak throughput: 5 cycles per word (4 transfers + 1 write) with `byte_valid` held high.
- Fetch must be held disabled while `done`=0; `done` rises the cycle after the terminator write, so the memory content is already stable.

## Test plan
- Load bytes 13 00 00 00, 00 00 00 00, BASE_ADDR=0, valid always high -> writes 0x00000013@0x0 then 0x00000000@0x4, `wr_en` high 2 cycles total, `done`=1, `word_count`=2, `error`=0.
- Same stream with `byte_valid` toggled 1-0-1-0 -> identical writes, each word's `wr_en` exactly one cycle after its 4th accepted byte, no byte lost or duplicated.
- Terminator only (00 00 00 00), BASE_ADDR=0x100 -> single write 0x0@0x100, `done`=1, `word_count`=1.
- DEPTH=4, five non-zero words (first 0x00000001) -> writes at 0x0, 0x4, 0x8, 0xC, then `error`=1, `done`=0, `word_count`=4, `byte_ready`=0; fifth word never written.
- Reset asserted after 2 bytes of the second word -> no second write, outputs at reset values. Then `start` plus a full two-word stream -> writes again from BASE_ADDR.
- After `done`, `start` again with bytes AA BB CC DD, 00 00 00 00 -> `done` clears the cycle after `start`, writes 0xDDCCBBAA@0x0, then terminator@0x4, `done`=1.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: assembles a little-endian byte stream into 32-bit program
// words and writes them to consecutive word addresses of instruction memory.
// Loading stops after the all-zero terminator word has been written (done),
// or when memory fills without a terminator (error).
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 256,
  localparam int         CW        = $clog2(DEPTH) + 1
) (
  input  logic          gated_clk,
  input  logic          reset,
  input  logic          start,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  output logic          wr_en,
  output logic [31:0]   wr_addr,
  output logic [31:0]   wr_data,
  output logic [CW-1:0] word_count,
  output logic          done,
  output logic          error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ASSEMBLE,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  byte_cnt;
  logic [23:0] buffer;
  logic        load;
  logic        xfer;
  logic        last_slot;

  // A load may only begin from a resting state; start is ignored mid-load.
  assign load      = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);
  assign xfer      = byte_valid && byte_ready;
  assign last_slot = (word_count == CW'(DEPTH - 1));

  // State register.
  always_ff @(posedge gated_clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; byte_ready and wr_en decode the state register only.
  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    wr_en      = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) state_nxt = S_ASSEMBLE;
      end
      S_ASSEMBLE: begin
        byte_ready = 1'b1;
        if (byte_valid && byte_cnt == 2'd3) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        wr_en = 1'b1;
        if (wr_data == 32'd0)  state_nxt = S_DONE;
        else if (last_slot)    state_nxt = S_ERROR;
        else                   state_nxt = S_ASSEMBLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Byte assembly, write address/data, word counter and sticky status flags.
  always_ff @(posedge gated_clk or posedge reset) begin
    if (reset) begin
      byte_cnt   <= 2'd0;
      buffer     <= 24'd0;
      wr_addr    <= BASE_ADDR;
      wr_data    <= 32'd0;
      word_count <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else if (load) begin
      byte_cnt   <= 2'd0;
      buffer     <= 24'd0;
      wr_addr    <= BASE_ADDR;
      word_count <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else if (state == S_ASSEMBLE && xfer) begin
      byte_cnt <= byte_cnt + 2'd1;
      case (byte_cnt)
        2'd0:    buffer[7:0]   <= byte_data;
        2'd1:    buffer[15:8]  <= byte_data;
        2'd2:    buffer[23:16] <= byte_data;
        default: wr_data       <= {byte_data, buffer};
      endcase
    end else if (state == S_WRITE) begin
      word_count <= word_count + CW'(1);
      if (wr_data == 32'd0) begin
        // Terminator stays at its own address so wr_addr names the last write.
        done <= 1'b1;
      end else if (last_slot) begin
        error <= 1'b1;
      end else begin
        wr_addr  <= wr_addr + 32'd4;
        byte_cnt <= 2'd0;
        buffer   <= 24'd0;
      end
    end
  end

endmodule
